// File: rtl/iterative_barrel_derotator.sv
// iterative_barrel_derotator
// Undoes the combinational barrel rotator one bit position per clock.
// The encoder rotates right when dir=1 and left when dir=0. This block rotates
// the opposite way the same number of positions, so it recovers the original word.
// WIDTH must equal 2**AMT_W. With that sizing, amt covers every distinct rotation.
module iterative_barrel_derotator #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;

    // The result is read straight from the working register. It holds steady in DONE,
    // and it holds the last result in IDLE.
    assign data_out = data_q;

    // Control FSM with datapath. The handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= data_in;
                        cnt_q    <= amt;
                        dir_q    <= dir;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Rotate against the encoder's direction, one position per clock.
                    if (dir_q)
                        data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    else
                        data_q <= {data_q[0], data_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_barrel_derotator.sv
// Testbench for iterative_barrel_derotator. It runs a table of directed vectors, then
// hand-written backpressure, SHIFT-noise and async-reset sequences, then a random
// round trip through an encoder model.
module tb_iterative_barrel_derotator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [2:0] amt;
    logic       dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       busy;

    int tests_run;
    int tests_failed;

    iterative_barrel_derotator #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .amt       (amt),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [2:0] a;
        logic       d;
        logic [7:0] exp;
    } vec_t;

    // Encoder model: dir=1 rotates right, dir=0 rotates left.
    function automatic logic [7:0] enc(input logic [7:0] x, input logic [2:0] a, input logic d);
        logic [15:0] xx;
        logic [15:0] sh;
        xx = {x, x};
        if (d) begin
            sh = xx >> a;
            return sh[7:0];
        end else begin
            sh = xx << a;
            return sh[15:8];
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one job and wait for its result, with latency bounded at 20 cycles.
    // Then complete the handshake with out_ready=1 and check the return to IDLE.
    task automatic run_job(input logic [7:0] din, input logic [2:0] a, input logic d,
                           input logic [7:0] exp, input string nm, input bit full);
        int lat;
        @(negedge clk);
        if (full) chk({nm, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        data_in   = din;
        amt       = a;
        dir       = d;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        amt      = 3'($urandom);
        dir      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (full) chk({nm, " latency"}, 32'(lat), 32'(a));
        chk({nm, " data_out"}, 32'(data_out), 32'(exp));
        @(posedge clk); #1;
        if (full) begin
            chk({nm, " out_valid after hs"}, 32'(out_valid), 32'd0);
            chk({nm, " in_ready after hs"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] held;
        tests_run    = 0;
        tests_failed = 0;
        in_valid  = 1'b0;
        data_in   = '0;
        amt       = '0;
        dir       = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        vecs[0] = '{8'hD2, 3'd3, 1'b1, 8'h96};
        vecs[1] = '{8'h5A, 3'd2, 1'b0, 8'h96};
        vecs[2] = '{8'hA5, 3'd0, 1'b0, 8'hA5};
        vecs[3] = '{8'h01, 3'd1, 1'b0, 8'h80};
        vecs[4] = '{8'h80, 3'd1, 1'b1, 8'h01};
        vecs[5] = '{8'h69, 3'd4, 1'b0, 8'h96};
        vecs[6] = '{8'hFF, 3'd5, 1'b1, 8'hFF};

        // Reset state
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].din, vecs[i].a, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);

        // amt=7 with noise on the inputs during SHIFT
        begin
            int lat;
            @(negedge clk);
            in_valid = 1'b1; data_in = 8'h2D; amt = 3'd7; dir = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            lat = 0;
            while (!out_valid && lat < 20) begin
                in_valid = ~in_valid;
                data_in  = 8'($urandom);
                amt      = 3'($urandom);
                dir      = 1'($urandom);
                chk("shift7 in_ready low", 32'(in_ready), 32'd0);
                chk("shift7 busy", 32'(busy), 32'd1);
                @(posedge clk); #1;
                lat++;
            end
            in_valid = 1'b0;
            chk("shift7 latency", 32'(lat), 32'd7);
            chk("shift7 data_out", 32'(data_out), 32'h96);
            @(posedge clk); #1;
            chk("shift7 back idle", 32'(in_ready), 32'd1);
        end

        // Backpressure in DONE
        begin
            int lat;
            @(negedge clk);
            in_valid = 1'b1; data_in = 8'hD2; amt = 3'd3; dir = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            chk("bp latency", 32'(lat), 32'd3);
            held = data_out;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk("bp out_valid held", 32'(out_valid), 32'd1);
                chk("bp data held", 32'(data_out), 32'h96);
                chk("bp in_ready low", 32'(in_ready), 32'd0);
            end
            chk("bp data vs first", 32'(data_out), 32'(held));
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp single xfer", 32'(out_valid), 32'd0);
            chk("bp idle in_ready", 32'(in_ready), 32'd1);
        end

        // Async reset mid-SHIFT
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h3C; amt = 3'd5; dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("pre-rst busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst data_out", 32'(data_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("post-rst no result", 32'(out_valid), 32'd0);

        // Random round trip through the encoder model
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] x;
            logic [2:0] a;
            logic       d;
            x = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            d = 1'($urandom);
            run_job(enc(x, a, d), a, d, x, $sformatf("rand%0d", n), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iterative_barrel_derotator.md
Name: iterative_barrel_derotator

Overview:
- Sequential inverse of the team's 8-bit multifunction barrel rotator.
- The encoder rotates right by amt when dir=1 and left by amt when dir=0. This block takes that rotated word with the same amt/dir and recovers the original word.
- It rotates one bit position per clock under a valid/ready handshake. It sits on the receive side of the datapath, opposite the combinational rotator.

Parameters:
- WIDTH, 8, data word width; must equal 2**AMT_W.
- AMT_W, 3, rotate-amount width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  rotated word, amt and dir are presented.
- in_ready  output  1  block can accept a new job.
- data_in  input  WIDTH  rotated word from the encoder.
- amt  input  AMT_W  rotate amount the encoder applied.
- dir  input  1  encoder direction: 1 = it rotated right, 0 = it rotated left.
- out_valid  output  1  recovered word is valid.
- out_ready  input  1  downstream accepts the result.
- data_out  output  WIDTH  recovered original word.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - Data register and count register = 0; stored direction = 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, data_out=0.
- States: IDLE, SHIFT, DONE. Encode with a 2-bit state register; the unused code returns to IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: capture data_in into the data register, amt into the count register, and dir into the stored direction.
  - If amt==0, go to DONE; otherwise go to SHIFT.
  - If in_valid=0, stay in IDLE.
- SHIFT:
  - Each edge rotates the data register by exactly 1 bit.
  - Stored dir=1: rotate left, {d[WIDTH-2:0], d[WIDTH-1]}.
  - Stored dir=0: rotate right, {d[0], d[WIDTH-1:1]}.
  - The count register decrements by 1 on each such edge. When count==1 at the edge, the final rotate happens and the state moves to DONE.
  - in_valid is ignored in SHIFT; in_ready=0.
- DONE:
  - out_valid=1 and data_out = data register; both are held stable until handshake.
  - When out_valid and out_ready are both 1 at an edge, return to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle accept-and-complete overlap. Throughput is one job per amt+2 cycles.
- Latency: with acceptance at edge k, out_valid is high starting after edge k+amt.
  - amt=0 gives out_valid in the cycle right after acceptance.
  - amt=WIDTH-1 (7) is the maximum, 7 cycles.
- data_out is a registered output; it is driven from the data register in every state.
- Changes on data_in, amt or dir after acceptance have no effect on the job in progress.
- Reset asserted mid-operation (SHIFT or DONE) aborts immediately: IDLE state, all outputs at their reset values, and no partial result is presented.
- out_ready held low in DONE: stay in DONE indefinitely with data stable.
- Functional invariant: encoder(x, amt, dir) fed into this block with the same amt and dir returns x, for every x, amt and dir.

Test Plan:
- Reset, then job data_in=8'hD2, amt=3, dir=1, out_ready=1 -> out_valid high 3 cycles after accept, data_out=8'h96, back to IDLE with in_ready=1 one cycle later.
- data_in=8'h5A, amt=2, dir=0 -> data_out=8'h96 after 2 cycles.
- amt=0, data_in=8'hA5, dir=0 -> out_valid the cycle after accept, data_out=8'hA5.
- amt=7, dir=1, data_in=8'h2D (8'h96 rotated right by 7) -> data_out=8'h96 after 7 cycles. During SHIFT, toggle in_valid and change data_in -> in_ready stays 0 and the result is unaffected.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable, in_ready=0. Raise out_ready -> single transfer, then IDLE.
- Assert rst_n=0 asynchronously mid-SHIFT, between clock edges -> out_valid=0, busy=0, in_ready=1, data_out=0 immediately. Release, run a random-loop self-check: for 1000 random x/amt/dir, feeding encoder(x) gives data_out=x.
